// File: rtl/pqr5_core_pkg.sv
// Shared PQR5 core definitions: opcodes, canonical NOP, fetch-FSM states
// and RV32 immediate extraction helpers used by the static predictor.
package pqr5_core_pkg;

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fu_pcgen_state_t;

  // B-type immediate, 13 bits including the implicit zero LSB
  function automatic logic [12:0] imm_b(input logic [31:0] instr);
    return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  // J-type immediate, 21 bits including the implicit zero LSB
  function automatic logic [20:0] imm_j(input logic [31:0] instr);
    return {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fu_static_predictor.sv
// Static branch predictor: JAL and backward conditional branches are
// predicted taken; everything else (forward branches, JALR) falls through.
module fu_static_predictor
  import pqr5_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [12:0]     ib;
  logic [20:0]     ij;
  logic [XLEN-1:0] ib_x;
  logic [XLEN-1:0] ij_x;
  logic [XLEN-1:0] tgt_b;
  logic [XLEN-1:0] tgt_j;
  logic            is_jal;
  logic            is_bwd_br;

  assign ib   = imm_b(instr);
  assign ij   = imm_j(instr);
  assign ib_x = {{(XLEN-13){ib[12]}}, ib};
  assign ij_x = {{(XLEN-21){ij[20]}}, ij};

  // separate adders so the select is off the add critical path
  assign tgt_b = pc + ib_x;
  assign tgt_j = pc + ij_x;

  assign is_jal    = (instr[6:0] == OP_JAL);
  assign is_bwd_br = (instr[6:0] == OP_BRANCH) && instr[31];

  assign pred_taken  = is_jal | is_bwd_br;
  assign pred_target = is_jal ? tgt_j : tgt_b;

endmodule

// File: rtl/fu_branch_predict_pcgen.sv
// Fetch-side PC generator: issues imem fetches, statically predicts each
// returned instruction, and presents pc/instr/bubble/taken to decode.
// Execution-unit flushes override everything, including stall.
module fu_branch_predict_pcgen
  import pqr5_core_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] PC_INIT = '0
) (
  input  logic            clk,
  input  logic            srst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_pc,
  input  logic [31:0]     i_imem_instr,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic            o_bubble,
  output logic            o_branch_taken
);

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] LOW2_MSK = XLEN'(3);

  fu_pcgen_state_t state;

  logic [XLEN-1:0] fetch_pc_rg;
  logic [XLEN-1:0] req_pc_rg;
  logic            inflight_rg;
  logic            drop_rg;

  logic            skid_vld_rg;
  logic [XLEN-1:0] skid_pc_rg;
  logic [31:0]     skid_instr_rg;
  logic            skid_taken_rg;

  logic            req_issue;
  logic            rsp_vld;
  logic            rsp_acc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] flush_pc_al;

  // Fetch only when nothing is parked in the skid buffer, so a buffered
  // instruction can never be overtaken by a newer response.
  assign req_issue = (state == S_RUN) && !skid_vld_rg && !i_stall && !i_flush && !srst;
  assign o_imem_req = req_issue;
  assign o_imem_pc  = fetch_pc_rg;

  // A response exists only the cycle after an issued request; a pending
  // drop marks it as the wrong-path sequential fetch.
  assign rsp_vld = inflight_rg && !drop_rg;
  assign rsp_acc = rsp_vld && !i_flush;

  assign flush_pc_al = i_flush_pc & ~LOW2_MSK;

  fu_static_predictor #(.XLEN(XLEN)) u_pred (
    .pc          (req_pc_rg),
    .instr       (i_imem_instr),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  // Fetch side: FSM, fetch PC selection (flush > prediction > sequential)
  // and in-flight/drop tracking.
  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= S_BOOT;
      fetch_pc_rg <= PC_INIT;
      req_pc_rg   <= PC_INIT;
      inflight_rg <= 1'b0;
      drop_rg     <= 1'b0;
    end else begin
      state       <= S_RUN;
      inflight_rg <= req_issue;
      // drop only ever covers the response arriving next cycle
      drop_rg     <= 1'b0;
      if (req_issue)
        req_pc_rg <= fetch_pc_rg;
      if (i_flush) begin
        fetch_pc_rg <= flush_pc_al;
        drop_rg     <= inflight_rg;
      end else if (rsp_acc && pred_taken) begin
        fetch_pc_rg <= pred_target;
        drop_rg     <= req_issue;
      end else if (req_issue) begin
        fetch_pc_rg <= fetch_pc_rg + PC_STEP;
      end
    end
  end

  // Decode side: output registers and the one-entry skid buffer that
  // absorbs the single response that can land during a stall.
  always_ff @(posedge clk) begin
    if (srst) begin
      o_pc           <= PC_INIT;
      o_instr        <= INSTR_NOP;
      o_bubble       <= 1'b1;
      o_branch_taken <= 1'b0;
      skid_vld_rg    <= 1'b0;
      skid_pc_rg     <= PC_INIT;
      skid_instr_rg  <= INSTR_NOP;
      skid_taken_rg  <= 1'b0;
    end else if (i_flush) begin
      o_bubble       <= 1'b1;
      o_branch_taken <= 1'b0;
      skid_vld_rg    <= 1'b0;
    end else if (i_stall) begin
      if (rsp_vld) begin
        skid_vld_rg   <= 1'b1;
        skid_pc_rg    <= req_pc_rg;
        skid_instr_rg <= i_imem_instr;
        skid_taken_rg <= pred_taken;
      end
    end else if (skid_vld_rg) begin
      o_pc           <= skid_pc_rg;
      o_instr        <= skid_instr_rg;
      o_bubble       <= 1'b0;
      o_branch_taken <= skid_taken_rg;
      skid_vld_rg    <= 1'b0;
    end else if (rsp_vld) begin
      o_pc           <= req_pc_rg;
      o_instr        <= i_imem_instr;
      o_bubble       <= 1'b0;
      o_branch_taken <= pred_taken;
    end else begin
      o_bubble       <= 1'b1;
      o_branch_taken <= 1'b0;
    end
  end

endmodule

// File: doc/fu_branch_predict_pcgen.md
Name: fu_branch_predict_pcgen

Overview:
Fetch-side PC generator for the PQR5 core. It issues instruction-memory fetches, statically predicts branches on each returned instruction, and hands the PC, instruction, bubble flag and predicted branch-taken status to decode; that status travels down the pipeline to the execution-side branch check. It consumes the execution unit's flush and branch-PC redirect, which always override its own prediction.

Parameters:
PC_INIT, 32'h0000_0000, PC fetched first after reset; must be word-aligned.
XLEN, 32, data/address width.

Ports:
clk  input  1  clock
srst  input  1  reset; one clock; reset is synchronous and active-high
o_imem_req  output  1  fetch request this cycle
o_imem_pc  output  XLEN  fetch address; valid when o_imem_req=1
i_imem_instr  input  32  instruction for the request issued the previous cycle; fixed 1-cycle latency, no backpressure
i_stall  input  1  downstream stall
i_flush  input  1  redirect from execution unit
i_flush_pc  input  XLEN  redirect target; bits [1:0] ignored, forced to 0
o_pc  output  XLEN  PC of o_instr
o_instr  output  32  instruction to decode
o_bubble  output  1  1 = o_instr invalid
o_branch_taken  output  1  predicted-taken flag for o_instr

Behaviour:
- Reset (srst=1 at posedge):
  - o_pc = PC_INIT, o_instr = 32'h0000_0013 (NOP), o_bubble = 1, o_branch_taken = 0.
  - o_imem_req = 0; fetch_pc_rg = PC_INIT; skid buffer empty; drop_rg = 0; inflight_rg = 0; state = S_BOOT.
  - Reset asserted mid-operation discards everything in flight, including the skid-buffer contents.
- States:
  - S_BOOT: one cycle, no request, then S_RUN.
  - S_RUN: o_imem_req = 1 when the skid buffer is empty, i_stall = 0 and i_flush = 0.
  - o_imem_pc = fetch_pc_rg.
  - On an issued request: inflight_rg <= 1, req_pc_rg <= fetch_pc_rg, fetch_pc_rg <= fetch_pc_rg + 4.
  - All address arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
- Response: in the cycle after an issued request, i_imem_instr belongs to req_pc_rg.
  - If drop_rg = 1, the response is discarded and drop_rg is cleared.
  - Otherwise the response goes to the output registers (i_stall = 0, buffer empty) or into the 1-entry skid buffer (i_stall = 1).
- Prediction, combinational on the accepted instruction at PC p:
  - opcode JAL (7'b1101111): taken; target = p + sext(immJ, x2).
  - opcode BRANCH (7'b1100011) with instr[31] = 1 (backward): taken; target = p + sext(immB, x2).
  - All other instructions, including forward branches and JALR: not taken.
  - Taken: o_branch_taken <= 1, fetch_pc_rg <= target. If a request was issued in the same cycle (sequential speculation), drop_rg <= 1. Penalty is 1 bubble.
- Output timing:
  - Normal latency: request at cycle N, response at N+1, registered output at N+2.
  - Sustained throughput is 1 instruction per cycle.
- Stall:
  - With i_stall = 1, all output registers hold and no new request is issued.
  - A response returning during the stall is captured in the skid buffer; its prediction is applied at capture time.
  - On stall release the buffer drains to the output first. Fetch resumes the cycle after the buffer empties.
  - No instruction is lost or duplicated.
- Flush: has highest priority, including over i_stall.
  - At the posedge: o_bubble <= 1, o_branch_taken <= 0, skid buffer cleared.
  - fetch_pc_rg <= {i_flush_pc[XLEN-1:2], 2'b00}.
  - drop_rg <= inflight_rg, so any response for a request issued in the flush cycle or the cycle before is discarded.
  - No request is issued in the flush cycle; fetch of the flush target starts the next cycle.
- Flush coinciding with a predicted-taken response: the flush wins and the prediction is discarded.
- A bubble output (no valid response and no buffered instruction, i_stall = 0) sets o_bubble = 1 and o_branch_taken = 0. o_pc and o_instr hold their previous values.

Decomposition:
- Shared package pqr5_core_pkg gains:
  - OP_JAL and OP_BRANCH (where not already present).
  - INSTR_NOP = 32'h0000_0013.
  - the state enum fu_pcgen_state_t {S_BOOT, S_RUN}.
- One combinational sub-module, fu_static_predictor, maps (pc, instr) to (pred_taken, pred_target). It holds the immediate extraction and both adders.
- Skid buffer, drop/inflight tracking and the FSM stay in the top module.

Test Plan:
- Reset, PC_INIT = 0, srst held 2 cycles -> o_bubble = 1, o_imem_req = 0 during reset and in S_BOOT. Requests then go to 0x0, 0x4, 0x8; outputs show o_pc 0x0, 0x4, 0x8 with o_bubble = 0 from 2 cycles after the first request.
- BEQ at 0x10 with immB = -8 -> that output has o_branch_taken = 1; the response for 0x14 is dropped; exactly one bubble; next valid o_pc = 0x08.
- BNE at 0x10 with immB = +16 -> o_branch_taken = 0; next o_pc = 0x14, no bubble.
- JAL at 0x20 with immJ = +0x100 -> o_branch_taken = 1; next valid o_pc = 0x120; JALR at 0x30 -> not taken.
- i_flush = 1 with i_flush_pc = 0x203 while a request is in flight -> o_bubble = 1 next cycle; the in-flight response is dropped; next o_imem_pc = 0x200; next valid o_pc = 0x200.
- i_stall held 3 cycles while a response returns -> outputs frozen and the skid buffer is captured. On release the buffered instruction appears first, followed by the next sequential PC, with no gaps or duplicates. Repeat with i_flush during the stall -> the buffer is cleared and fetch restarts at the flush target.
